mandelbrot_iterator: RTL and testbench
======================================

MANDELBROT_ITERATOR -- requirements
Module: mandelbrot_iterator

Interface
REQ-001 SHALL have parameter WIDTH, default 8, giving the coordinate width in signed 2.(WIDTH-2) format.
REQ-002 SHALL have parameter CTR_WIDTH, default 8, giving the iteration counter width.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-005 SHALL have ports in_cr and in_ci, input, WIDTH, signed point coordinates.
REQ-006 SHALL have port in_max_iter, input, CTR_WIDTH, iteration limit for the job.
REQ-007 SHALL have ports in_valid (input, 1) and in_ready (output, 1) forming the job-accept handshake.
REQ-008 SHALL have port out_iter, output, CTR_WIDTH, iteration count at termination.
REQ-009 SHALL have port out_escaped, output, 1, set when the point diverged.
REQ-010 SHALL have ports out_valid (output, 1) and out_ready (input, 1) forming the result handshake.

Function
REQ-011 SHALL implement FSM states IDLE, ITER and DONE, with transitions only on clk.
REQ-012 SHALL drive in_ready high only in IDLE; in_valid&&in_ready latches cr, ci and max_iter, clears zr, zi and iter, and moves to ITER.
REQ-013 SHALL feed the step unit with latched cr/ci and current zr/zi each ITER cycle; size flags |z|^2>4 on current z, overflow flags an unrepresentable next z.
REQ-014 SHALL, in ITER, if size||overflow: latch out_iter=iter, out_escaped=1, go DONE.
REQ-015 SHALL, in ITER, else if iter==max_iter_q: latch out_iter=iter, out_escaped=0, go DONE.
REQ-016 SHALL, in ITER, otherwise load zr/zi with step outputs and increment iter (no wrap possible, bounded by max_iter_q).
REQ-017 SHALL drive out_valid high only in DONE; outputs held stable while out_ready is low; out_valid&&out_ready returns to IDLE.
REQ-018 SHALL give latency: termination at iter=n yields out_valid exactly n+2 rising edges after the accepting edge.
REQ-019 SHALL, for max_iter=0, terminate in the first ITER cycle with out_iter=0, out_escaped=0 unless size/overflow.
REQ-020 SHALL ignore in_valid outside IDLE; DONE-to-IDLE costs one bubble cycle before the next accept.

Reset
REQ-021 SHALL, with rst high, set state=IDLE, in_ready=0, out_valid=0, out_iter=0, out_escaped=0, zr=zi=iter=0.
REQ-022 SHALL, on rst asserted mid-ITER or mid-DONE, discard the job with no result emitted; in_ready rises the first cycle after rst deasserts.

Configuration
REQ-023 SHALL, with MANDEL_PERIOD_CHECK_EN defined, snapshot z when iter is a nonzero power of two and not terminating.
REQ-024 SHALL, with MANDEL_PERIOD_CHECK_EN, terminate early when the step output equals a valid snapshot and no escape, reporting out_iter=max_iter_q, out_escaped=0; escape takes precedence.
REQ-025 SHALL, without MANDEL_PERIOD_CHECK_EN, omit snapshot registers and comparator; behaviour per REQ-014..016 only.

Structure
REQ-026 SHALL place FSM state encoding (IDLE/ITER/DONE) and fixed-point constant ONE=1<<(WIDTH-2) in shared package mandelbrot_pkg.
REQ-027 SHALL instantiate exactly one sub-module, mandelbrot_alu (existing combinational step unit), with WIDTH passed through.

Verification
REQ-028 SHALL cover: cr=64 (1.0), ci=0, max=15 -> out_iter=1, out_escaped=1, out_valid 3 edges after accept.
REQ-029 SHALL cover: cr=0, ci=0, max=15, macro off -> out_iter=15, out_escaped=0, out_valid 17 edges after accept.
REQ-030 SHALL cover: cr=0, ci=0, max=15, macro on -> out_iter=15, out_escaped=0, out_valid 3 edges after accept (period hit at iter=1).
REQ-031 SHALL cover: max=0, c=0 -> out_iter=0, out_escaped=0 after 2 edges.
REQ-032 SHALL cover: out_ready low 5 cycles in DONE -> out_valid, out_iter, out_escaped unchanged; release -> IDLE next edge.
REQ-033 SHALL cover: rst pulsed at iter=4 of a max=15 job -> no out_valid, all outputs 0, new job accepted and correct.

Source files
------------

// File: rtl/mandelbrot_pkg.sv
// Shared types and fixed-point constants for the Mandelbrot iterator.
// Coordinates are signed 2.(WIDTH-2) fixed point.
package mandelbrot_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int WIDTH_DEF = 8;

  function automatic longint fx_one(input int width);
    return longint'(1) << (width - 2);
  endfunction

  localparam longint ONE = fx_one(WIDTH_DEF);

endpackage

// File: rtl/mandelbrot_alu.sv
// Combinational z <- z^2 + c step with escape (|z|^2 > 4)
// and next-z representability flags.
module mandelbrot_alu
  import mandelbrot_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic signed [WIDTH-1:0] cr,
  input  logic signed [WIDTH-1:0] ci,
  input  logic signed [WIDTH-1:0] zr,
  input  logic signed [WIDTH-1:0] zi,
  output logic signed [WIDTH-1:0] next_zr,
  output logic signed [WIDTH-1:0] next_zi,
  output logic                    size,
  output logic                    overflow
);

  localparam int FRAC = WIDTH - 2;
  localparam int PW   = 2 * WIDTH + 2;

  localparam logic signed [PW-1:0] ONE_W =
    PW'(fx_one(WIDTH));
  localparam logic signed [PW-1:0] LIM =
    (ONE_W * ONE_W) <<< 2;

  logic signed [PW-1:0] zr_x, zi_x;
  logic signed [PW-1:0] cr_x, ci_x;
  logic signed [PW-1:0] zr2, zi2, zri;
  logic signed [PW-1:0] mag;
  logic signed [PW-1:0] re_full, im_full;
  logic                 re_ok, im_ok;

  assign zr_x = {{(PW-WIDTH){zr[WIDTH-1]}}, zr};
  assign zi_x = {{(PW-WIDTH){zi[WIDTH-1]}}, zi};
  assign cr_x = {{(PW-WIDTH){cr[WIDTH-1]}}, cr};
  assign ci_x = {{(PW-WIDTH){ci[WIDTH-1]}}, ci};

  assign zr2 = zr_x * zr_x;
  assign zi2 = zi_x * zi_x;
  assign zri = zr_x * zi_x;
  assign mag = zr2 + zi2;

  // products carry 2*FRAC fraction bits; floor back to FRAC
  assign re_full = ((zr2 - zi2) >>> FRAC) + cr_x;
  assign im_full = ((zri <<< 1) >>> FRAC) + ci_x;

  assign re_ok = re_full[PW-1:WIDTH-1] ==
                 {(PW-WIDTH+1){re_full[WIDTH-1]}};
  assign im_ok = im_full[PW-1:WIDTH-1] ==
                 {(PW-WIDTH+1){im_full[WIDTH-1]}};

  assign next_zr  = re_full[WIDTH-1:0];
  assign next_zi  = im_full[WIDTH-1:0];
  assign size     = mag > LIM;
  assign overflow = !(re_ok && im_ok);

endmodule

// File: rtl/mandelbrot_iterator.sv
// Per-point Mandelbrot iteration FSM (IDLE/ITER/DONE).
// Optional cycle detection: define MANDEL_PERIOD_CHECK_EN.
module mandelbrot_iterator
  import mandelbrot_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int CTR_WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic signed [WIDTH-1:0] in_cr,
  input  logic signed [WIDTH-1:0] in_ci,
  input  logic [CTR_WIDTH-1:0]    in_max_iter,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [CTR_WIDTH-1:0]    out_iter,
  output logic                    out_escaped,
  output logic                    out_valid,
  input  logic                    out_ready
);

  state_t state;

  logic signed [WIDTH-1:0] cr_q, ci_q;
  logic signed [WIDTH-1:0] zr_q, zi_q;
  logic [CTR_WIDTH-1:0]    max_q, iter_q;
  logic [CTR_WIDTH-1:0]    iter_nx;

  logic signed [WIDTH-1:0] nzr, nzi;
  logic                    size, ovf;
  logic                    escape, at_max;
  logic                    period_hit;
  logic                    accept;

  mandelbrot_alu #(
    .WIDTH(WIDTH)
  ) u_alu (
    .cr      (cr_q),
    .ci      (ci_q),
    .zr      (zr_q),
    .zi      (zi_q),
    .next_zr (nzr),
    .next_zi (nzi),
    .size    (size),
    .overflow(ovf)
  );

  assign escape  = size || ovf;
  assign at_max  = iter_q == max_q;
  assign iter_nx = iter_q + CTR_WIDTH'(1);
  assign accept  = (state == IDLE) && in_valid && in_ready;

`ifdef MANDEL_PERIOD_CHECK_EN
  logic signed [WIDTH-1:0] snap_r, snap_i;
  logic                    snap_v;
  logic                    pow2;

  // iter_nx is never zero here: iter < max_q while stepping
  assign pow2 = (iter_nx & (iter_nx - CTR_WIDTH'(1))) == '0;

  assign period_hit = snap_v && (nzr == snap_r) &&
                      (nzi == snap_i);

  // capture z on entering each power-of-two iteration
  always_ff @(posedge clk) begin
    if (rst) begin
      snap_r <= '0;
      snap_i <= '0;
      snap_v <= 1'b0;
    end else if (accept) begin
      snap_v <= 1'b0;
    end else if (state == ITER && !escape &&
                 !at_max && !period_hit && pow2) begin
      snap_r <= nzr;
      snap_i <= nzi;
      snap_v <= 1'b1;
    end
  end
`else
  assign period_hit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      in_ready    <= 1'b0;
      out_valid   <= 1'b0;
      out_iter    <= '0;
      out_escaped <= 1'b0;
      cr_q        <= '0;
      ci_q        <= '0;
      max_q       <= '0;
      zr_q        <= '0;
      zi_q        <= '0;
      iter_q      <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            cr_q     <= in_cr;
            ci_q     <= in_ci;
            max_q    <= in_max_iter;
            zr_q     <= '0;
            zi_q     <= '0;
            iter_q   <= '0;
            in_ready <= 1'b0;
            state    <= ITER;
          end else begin
            in_ready <= 1'b1;
          end
        end
        ITER: begin
          if (escape) begin
            out_iter    <= iter_q;
            out_escaped <= 1'b1;
            out_valid   <= 1'b1;
            state       <= DONE;
          end else if (at_max || period_hit) begin
            out_iter    <= max_q;
            out_escaped <= 1'b0;
            out_valid   <= 1'b1;
            state       <= DONE;
          end else begin
            zr_q   <= nzr;
            zi_q   <= nzi;
            iter_q <= iter_nx;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mandelbrot_iterator.sv
// Directed-vector bench for mandelbrot_iterator.
// Expectations follow MANDEL_PERIOD_CHECK_EN when defined.
module tb_mandelbrot_iterator;

  logic              clk = 1'b0;
  logic              rst;
  logic signed [7:0] in_cr, in_ci;
  logic [7:0]        in_max_iter;
  logic              in_valid, in_ready;
  logic [7:0]        out_iter;
  logic              out_escaped, out_valid, out_ready;

  int total  = 0;
  int passed = 0;

  always #5 clk = ~clk;

  mandelbrot_iterator #(
    .WIDTH(8),
    .CTR_WIDTH(8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_cr      (in_cr),
    .in_ci      (in_ci),
    .in_max_iter(in_max_iter),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out_iter   (out_iter),
    .out_escaped(out_escaped),
    .out_valid  (out_valid),
    .out_ready  (out_ready)
  );

  // one job; accepting edge counts as edge 1
  task automatic run_job(input string name, input int cr,
                         input int ci, input int mx,
                         input int exp_it, input int exp_esc,
                         input int exp_lat);
    int edges;
    int waits;
    @(negedge clk);
    waits = 0;
    while (!in_ready && waits < 20) begin
      @(negedge clk);
      waits++;
    end
    total++;
    if (in_ready !== 1'b1) begin
      $display("FAIL %s_ready: in_ready=%b required 1",
               name, in_ready);
      return;
    end else passed++;
    in_cr       = 8'(cr);
    in_ci       = 8'(ci);
    in_max_iter = 8'(mx);
    in_valid    = 1'b1;
    @(posedge clk);
    edges = 1;
    @(negedge clk);
    // junk job held on the bus must be ignored while busy
    in_cr       = -8'sd128;
    in_ci       = -8'sd128;
    in_max_iter = 8'd0;
    while (!out_valid && edges < 200) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
    end
    total++;
    if (edges !== exp_lat)
      $display("FAIL %s_latency: got %0d required %0d",
               name, edges, exp_lat);
    else passed++;
    total++;
    if (out_iter !== 8'(exp_it))
      $display("FAIL %s_iter: got %0d required %0d",
               name, out_iter, exp_it);
    else passed++;
    total++;
    if (out_escaped !== 1'(exp_esc))
      $display("FAIL %s_escaped: got %b required %0d",
               name, out_escaped, exp_esc);
    else passed++;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    in_valid  = 1'b0;
    total++;
    if (out_valid !== 1'b0)
      $display("FAIL %s_release: out_valid=%b required 0",
               name, out_valid);
    else passed++;
  endtask

  task automatic test_reset();
    rst         = 1'b1;
    in_valid    = 1'b0;
    out_ready   = 1'b0;
    in_cr       = '0;
    in_ci       = '0;
    in_max_iter = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    total++;
    if (in_ready !== 1'b0)
      $display("FAIL rst_in_ready: got %b required 0", in_ready);
    else passed++;
    total++;
    if (out_valid !== 1'b0)
      $display("FAIL rst_out_valid: got %b required 0", out_valid);
    else passed++;
    total++;
    if (out_iter !== 8'd0)
      $display("FAIL rst_out_iter: got %0d required 0", out_iter);
    else passed++;
    total++;
    if (out_escaped !== 1'b0)
      $display("FAIL rst_out_escaped: got %b required 0",
               out_escaped);
    else passed++;
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    total++;
    if (in_ready !== 1'b1)
      $display("FAIL rst_release_ready: got %b required 1",
               in_ready);
    else passed++;
  endtask

  task automatic test_escape();
    run_job("esc_one", 64, 0, 15, 1, 1, 3);
    run_job("esc_minus_two", -128, 0, 15, 1, 1, 3);
    run_job("esc_size", -128, -128, 15, 1, 1, 3);
    run_job("esc_half", 32, 0, 15, 4, 1, 6);
    run_job("esc_at_max", 64, 0, 1, 1, 1, 3);
  endtask

  task automatic test_interior();
`ifdef MANDEL_PERIOD_CHECK_EN
    run_job("int_zero", 0, 0, 15, 15, 0, 3);
    run_job("int_i_cycle", 0, 64, 15, 15, 0, 5);
`else
    run_job("int_zero", 0, 0, 15, 15, 0, 17);
    run_job("int_i_cycle", 0, 64, 15, 15, 0, 17);
`endif
    run_job("int_max_one", 16, 0, 1, 1, 0, 3);
  endtask

  task automatic test_max_zero();
    run_job("max_zero", 0, 0, 0, 0, 0, 2);
  endtask

  task automatic test_backpressure();
    int waits;
    @(negedge clk);
    waits = 0;
    while (!in_ready && waits < 20) begin
      @(negedge clk);
      waits++;
    end
    in_cr       = 8'sd32;
    in_ci       = 8'sd0;
    in_max_iter = 8'd15;
    in_valid    = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    waits = 0;
    while (!out_valid && waits < 100) begin
      @(negedge clk);
      waits++;
    end
    for (int k = 0; k < 5; k++) begin
      total++;
      if (out_valid !== 1'b1)
        $display("FAIL bp_valid_%0d: got %b required 1",
                 k, out_valid);
      else passed++;
      total++;
      if (out_iter !== 8'd4)
        $display("FAIL bp_iter_%0d: got %0d required 4",
                 k, out_iter);
      else passed++;
      total++;
      if (out_escaped !== 1'b1)
        $display("FAIL bp_escaped_%0d: got %b required 1",
                 k, out_escaped);
      else passed++;
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    total++;
    if (out_valid !== 1'b0)
      $display("FAIL bp_release: out_valid=%b required 0",
               out_valid);
    else passed++;
    total++;
    if (in_ready !== 1'b0)
      $display("FAIL bp_bubble: in_ready=%b required 0",
               in_ready);
    else passed++;
    @(posedge clk);
    @(negedge clk);
    total++;
    if (in_ready !== 1'b1)
      $display("FAIL bp_ready_after: in_ready=%b required 1",
               in_ready);
    else passed++;
  endtask

  task automatic test_reset_mid();
    int waits;
    logic seen;
    @(negedge clk);
    waits = 0;
    while (!in_ready && waits < 20) begin
      @(negedge clk);
      waits++;
    end
    in_cr       = 8'sd0;
    in_ci       = 8'sd0;
    in_max_iter = 8'd15;
    in_valid    = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    total++;
    if (out_valid !== 1'b0)
      $display("FAIL mid_rst_valid: got %b required 0", out_valid);
    else passed++;
    total++;
    if (in_ready !== 1'b0)
      $display("FAIL mid_rst_ready: got %b required 0", in_ready);
    else passed++;
    total++;
    if (out_iter !== 8'd0)
      $display("FAIL mid_rst_iter: got %0d required 0", out_iter);
    else passed++;
    total++;
    if (out_escaped !== 1'b0)
      $display("FAIL mid_rst_escaped: got %b required 0",
               out_escaped);
    else passed++;
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    total++;
    if (in_ready !== 1'b1)
      $display("FAIL mid_rst_ready_rise: got %b required 1",
               in_ready);
    else passed++;
    seen = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (out_valid) seen = 1'b1;
      @(negedge clk);
    end
    total++;
    if (seen !== 1'b0)
      $display("FAIL mid_rst_no_result: out_valid seen=%b required 0",
               seen);
    else passed++;
    run_job("after_rst", 64, 0, 15, 1, 1, 3);
  endtask

  initial begin
    test_reset();
    test_escape();
    test_interior();
    test_max_zero();
    test_backpressure();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
